// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge.
package spi_reg_pkg;

  // Transaction phase within a chip-select frame.
  typedef enum logic [1:0] {
    S_CMD = 2'd0,
    S_WR  = 2'd1,
    S_RD  = 2'd2
  } state_t;

  localparam int         CMD_RD_BIT = 7;
  localparam logic [6:0] ID_ADDR    = 7'h7F;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;

  // True when addr selects a physical read/write register.
  function automatic logic addr_in_range(input logic [6:0] addr, input logic [7:0] num_regs);
    return {1'b0, addr} < num_regs;
  endfunction

endpackage

// File: rtl/spi_reg_file.sv
// Register file: synchronous write port, combinational read port with
// ID / out-of-range decode, and a flat view of every register.
module spi_reg_file
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] ID_VALUE  = 8'h5A
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [6:0]            waddr,
  input  logic [7:0]            wdata,
  input  logic [6:0]            raddr,
  output logic [7:0]            rdata,
  output logic                  rerr,
  output logic [NUM_REGS*8-1:0] regs_out
);

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic [NUM_REGS*8-1:0] w_flat;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [7:0] r_q;

    // One storage byte; written only when the write port addresses it.
    // NOTE: this storage is flops, not RAM, so it takes the async reset value;
    // a real RAM macro could not be reset this way.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= RESET_VAL;
      end else if (we && (waddr == 7'(gi))) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        r_q <= wdata;
      end
    end

    assign w_flat[8*gi +: 8] = r_q;
  end

  assign regs_out = w_flat;

  // Read decode: ID constant at 7F, registers below NUM_REGS, else error.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    rdata = DUMMY_BYTE;
    rerr  = 1'b0;
    if (raddr == ID_ADDR) begin
      rdata = ID_VALUE;
    end else if (!addr_in_range(raddr, NUM_REGS_W)) begin
      rerr = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (raddr == 7'(i)) rdata = w_flat[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes SPI bytes into register read/write bursts framed by chip select.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] ID_VALUE  = 8'h5A
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_read,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  slave_error,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  err_sticky,
  input  logic                  err_clear
);

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic       r_cs_meta, r_cs_sync, r_cs_prev;
  logic       w_cs_fall, w_cs_rise, w_frame_end;
  state_t     r_state, w_state_next;
  logic [6:0] r_addr, w_addr_next, w_rd_addr;
  logic [7:0] w_rd_data, w_tx_byte;
  logic       w_rd_err, w_rd_req, w_tx_load, w_wr_en, w_wr_err, w_err_set;
  logic [7:0] r_tx_data, r_wr_data;
  logic       r_tx_valid, r_wr_strobe, r_err;
  logic [6:0] r_wr_addr;

  // Bytes are always accepted the cycle they arrive.
  assign rx_read = rx_valid;

  // Chip-select synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_meta <= cs_n;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
    end
  end

  assign w_cs_fall   = r_cs_prev && !r_cs_sync;
  assign w_cs_rise   = !r_cs_prev && r_cs_sync;
  assign w_frame_end = w_cs_rise || slave_error;

  spi_reg_file #(
    .NUM_REGS (NUM_REGS),
    .RESET_VAL(RESET_VAL),
    .ID_VALUE (ID_VALUE)
  ) u_reg_file (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (w_wr_en),
    .waddr   (r_addr),
    .wdata   (rx_data),
    .raddr   (w_rd_addr),
    .rdata   (w_rd_data),
    .rerr    (w_rd_err),
    .regs_out(regs_out)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_CMD;
    else          r_state <= w_state_next;
  end

  // Byte decode: next state, pointer, tx load and write request.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_rd_addr    = r_addr;
    w_rd_req     = 1'b0;
    w_tx_load    = 1'b0;
    w_tx_byte    = DUMMY_BYTE;
    w_wr_en      = 1'b0;
    w_wr_err     = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_CMD: begin
          w_rd_addr = rx_data[6:0];
          w_tx_load = 1'b1;
          if (rx_data[CMD_RD_BIT]) begin
            w_state_next = S_RD;
            w_rd_req     = 1'b1;
            w_tx_byte    = w_rd_data;
            w_addr_next  = rx_data[6:0] + 7'd1;
          end else begin
            w_state_next = S_WR;
            w_addr_next  = rx_data[6:0];
          end
        end
        S_WR: begin
          // 7F is never in range, so the read-only ID also errors here.
          w_wr_en     = addr_in_range(r_addr, NUM_REGS_W);
          w_wr_err    = !w_wr_en;
          w_tx_load   = 1'b1;
          w_addr_next = r_addr + 7'd1;
        end
        S_RD: begin
          w_rd_req    = 1'b1;
          w_tx_load   = 1'b1;
          w_tx_byte   = w_rd_data;
          w_addr_next = r_addr + 7'd1;
        end
        default: w_state_next = S_CMD;
      endcase
    end
    // A frame boundary overrides the phase; any byte this cycle still counts.
    if (w_cs_fall || w_frame_end) w_state_next = S_CMD;
  end

  assign w_err_set = (w_rd_req && w_rd_err) || w_wr_err || slave_error;

  // Pointer, transmit holding register, write echo and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= 7'd0;
      r_tx_data   <= DUMMY_BYTE;
      r_tx_valid  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 7'd0;
      r_wr_data   <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_addr      <= w_addr_next;
      r_wr_strobe <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= r_addr;
        r_wr_data <= rx_data;
      end

      if (w_frame_end) begin
        r_tx_valid <= 1'b0;
      end else if (w_cs_fall) begin
        r_tx_data  <= DUMMY_BYTE;
        r_tx_valid <= 1'b1;
      end else if (w_tx_load) begin
        r_tx_data  <= w_tx_byte;
        r_tx_valid <= 1'b1;
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end

      // A new error beats a simultaneous clear.
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clear) r_err <= 1'b0;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign err_sticky = r_err;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of spi_slave.
- Consumes received bytes (rx_data/rx_valid) and decodes them as register-access commands against a local register file.
- Feeds read-back bytes to the slave's transmit port (tx_data/tx_valid/tx_ready).
- Frames transactions on chip-select, so the SoC gets a byte-addressable SPI control/status register space.

Parameters:
- NUM_REGS, 16, number of 8-bit read/write registers (1..127), addresses 0..NUM_REGS-1.
- RESET_VAL, 8'h00, reset value of every register.
- ID_VALUE, 8'h5A, constant returned on reads of address 7'h7F.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cs_n  in  1  raw SPI chip select; synchronised internally (2 flops)
- rx_data  in  8  received byte from slave
- rx_valid  in  1  single-cycle pulse, rx_data valid
- rx_read  out  1  byte consumed acknowledge
- tx_data  out  8  next byte to shift out
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  slave can accept tx_data
- slave_error  in  1  slave abort pulse
- regs_out  out  NUM_REGS*8  flat register contents; reg i at bits [8i+7:8i]
- wr_strobe  out  1  one-cycle pulse per register write
- wr_addr  out  7  address of the write
- wr_data  out  8  data of the write
- err_sticky  out  1  sticky protocol/address error
- err_clear  in  1  clears err_sticky

Behaviour:
- Reset values: state S_CMD; addr pointer 0; all regs RESET_VAL; tx_data 8'h00; tx_valid, rx_read, wr_strobe, err_sticky 0; wr_addr 0; wr_data 0.
- Command byte format: bit7 = 1 read / 0 write; bits6:0 = start address.
- Frame start: cs_n sync falling edge.
  - State forced to S_CMD.
  - Dummy byte 8'h00 presented on tx (tx_valid=1).
- States:
  - S_CMD
    - On rx_valid: addr <= rx_data[6:0].
    - Read: next state S_RD; load tx_data from rd(addr); addr <= addr+1.
    - Write: next state S_WR; load tx_data 8'h00.
  - S_WR
    - On rx_valid: if addr < NUM_REGS, reg[addr] <= rx_data and pulse wr_strobe with wr_addr/wr_data. Otherwise no write and err_sticky <= 1; addr 7'h7F is read-only, so writes to it also error.
    - Then addr <= addr+1 and tx_data <= 8'h00.
  - S_RD
    - On each rx_valid (MOSI byte ignored): load tx_data from rd(addr); addr <= addr+1.
- rd(a):
  - reg[a] if a < NUM_REGS.
  - ID_VALUE if a == 7'h7F.
  - Otherwise 8'h00 and err_sticky <= 1.
- Address pointer is 7 bits and wraps 7'h7F -> 7'h00 (auto-increment burst).
- Latency:
  - rx_read asserted in the same cycle as rx_valid, combinationally.
  - Register write and tx_data/tx_valid update in the cycle after rx_valid (registered).
- Tx handshake:
  - tx_valid stays high until a cycle with tx_valid && tx_ready, then drops.
  - A new load while tx_valid is still high overwrites tx_data; latest wins.
- Frame end or abort:
  - Triggers: cs_n sync rising edge, or slave_error pulse.
  - Effect: state <= S_CMD, tx_valid <= 0.
  - Frame end mid-command (no byte yet) is not an error.
  - slave_error sets err_sticky.
- Simultaneous events:
  - rx_valid and a cs_n rising edge in the same cycle: the byte is processed (write committed), then the state returns to S_CMD.
  - err_clear with a new error source in the same cycle: set wins.
- Register contents persist across frames; only reset_n restores RESET_VAL.
- Reset assertion mid-frame clears everything immediately, asynchronously.

Decomposition:
- Package spi_reg_pkg:
  - state enum {S_CMD, S_WR, S_RD}
  - CMD_RD_BIT = 7
  - ID_ADDR = 7'h7F
  - DUMMY_BYTE = 8'h00
- One sub-module: spi_reg_file.
  - Synchronous write port: we, waddr, wdata.
  - Combinational read port: raddr -> rdata, with ID/out-of-range decode.
  - Drives regs_out.

Test Plan:
- Write single: frame bytes 8'h03, 8'hC4 -> reg3 = C4; one wr_strobe with wr_addr 3, wr_data C4; err_sticky 0.
- Read single after the write: frame 8'h83, 8'h00 -> tx_data after command byte = C4; tx_valid drops after tx_ready handshake.
- Burst write with wrap, NUM_REGS=16: frame 8'h0E, 11, 22, 33 -> reg14 = 11, reg15 = 22; addr 16 write ignored; err_sticky = 1; err_clear pulse -> 0.
- ID read: frame 8'hFF, 8'h00, 8'h00 -> tx bytes 5A then reg0 (addr wrapped to 0); err_sticky 0.
- Abort: frame 8'h05, then cs_n high before the data byte; next frame 8'h85, 8'h00 -> reg5 unchanged (RESET_VAL); a slave_error pulse sets err_sticky and returns to S_CMD.
- Reset mid-frame: reset_n low during S_WR after regs written -> all regs 00, tx_valid 0, state S_CMD; a new write frame works normally.
